xup_rr_arbiter4: RTL and testbench
==================================

XUP_RR_ARBITER4 -- requirements
Module: xup_rr_arbiter4

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles per owner while others wait (legal 1..255).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset_n  input  1  synchronous active-low reset.
REQ-005 Port: req  input  4  request lines, bit i = requester i, level-sensitive.
REQ-006 Port: gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-007 Port: gnt_id  output  2  binary index of current owner, 0 when idle.
REQ-008 Port: busy  output  1  high whenever any gnt bit is high.

Function
REQ-009 State machine SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-010 Arbitration SHALL be round-robin: search starts at (last + 1) mod 4, wraps 3->0, and picks the first requesting index.
REQ-011 last SHALL update to the new owner index on every grant change.
REQ-012 IDLE -> GRANT: at the first edge where req != 0, the picked requester owns; gnt is visible the cycle after req is sampled (1-cycle latency).
REQ-013 GRANT, req[owner]=1, hold_cnt < MAX_HOLD-1: owner kept, hold_cnt increments.
REQ-014 GRANT, req[owner]=1, hold_cnt = MAX_HOLD-1, other req pending: grant SHALL rotate to the next pick (owner excluded) at that edge; hold_cnt := 0.
REQ-015 GRANT, req[owner]=1, hold_cnt = MAX_HOLD-1, no other req: owner kept, hold_cnt := 0 (no forced release).
REQ-016 GRANT, req[owner]=0, other req pending: grant SHALL transfer directly to the next pick at that edge, no idle cycle; hold_cnt := 0.
REQ-017 GRANT, req[owner]=0, no other req: -> IDLE, gnt := 0, gnt_id := 0, hold_cnt := 0.
REQ-018 gnt SHALL never have more than one bit set; gnt, gnt_id, busy SHALL change only on clock edges.
REQ-019 A requester deasserting while not owner SHALL lose nothing; no request is latched (level-sensitive only).
REQ-020 hold_cnt SHALL be 8 bits wide and never exceed MAX_HOLD-1.
REQ-021 MAX_HOLD = 1 SHALL rotate every cycle while two or more requesters are active.

Reset
REQ-022 While reset_n=0 at a rising edge: state := IDLE, gnt := 0, gnt_id := 0, busy := 0, hold_cnt := 0, last := 3 (requester 0 has first priority).
REQ-023 Reset asserted mid-grant SHALL clear the grant at that edge regardless of req; arbitration resumes on the first edge with reset_n=1.

Structure
REQ-024 State encodings (IDLE=0, GRANT=1) and the requester count (4) SHALL live in a shared package/include for the XUP arbiter family.
REQ-025 The combinational round-robin picker (inputs req, last, exclude-owner flag; outputs found, index) SHALL be a sub-module named xup_rr_pick4.
REQ-026 All state SHALL be in one clocked process; no latches; no gate-level delays in this block.

Verification
REQ-027 Reset then req=4'b0000 for 5 cycles -> gnt=0, busy=0, gnt_id=0 throughout.
REQ-028 req=4'b1111 held, MAX_HOLD=8 -> owners 0,1,2,3,0 each for exactly 8 cycles, first gnt=4'b0001 one cycle after req rises.
REQ-029 Owner 2 holds, req[2] drops while req=4'b1001 -> next edge gnt=4'b1000 (index 3, wrap order), no idle cycle.
REQ-030 Only req[1]=1 for 20 cycles, MAX_HOLD=8 -> gnt=4'b0010 continuously, hold_cnt wraps 7->0, no release.
REQ-031 req=4'b0110, owner 1 at cycle 3, reset_n=0 for one cycle -> gnt=0 at that edge; after release, req=4'b0110 -> gnt=4'b0010 (last reset to 3).
REQ-032 MAX_HOLD=1, req=4'b0101 -> gnt alternates 4'b0001/4'b0100 every cycle; one-hot checked every cycle.

Source files
------------

// File: rtl/xup_arb_pkg.sv
// Shared definitions for the XUP arbiter family.
// Latency: none (definitions only).
// Backpressure: not applicable.
package xup_arb_pkg;

  // Number of requesters served by the 4-way arbiters.
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  // Arbiter FSM: IDLE has no owner, GRANT has exactly one owner.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // One-hot grant vector for a binary requester index.
  function automatic logic [NUM_REQ-1:0] onehot_of(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/xup_rr_pick4.sv
// Combinational round-robin picker for 4 requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result simply follows the inputs.
//
// Ports:
//   req   [3:0] in  : request lines
//   last  [1:0] in  : index granted most recently; search starts at last+1
//   excl        in  : when set, index 'last' itself is never picked
//   found       out : some eligible requester exists
//   idx   [1:0] out : first eligible requester in wrap order
module xup_rr_pick4
  import xup_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  input  logic               excl,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  // Walk offsets 1..4 from 'last'; offset 4 wraps back onto 'last' itself,
  // which is the candidate dropped when the current owner is excluded.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + ID_W'(k);
      if (!found && !(excl && (k == NUM_REQ)) && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/xup_rr_arbiter4.sv
// 4-way round-robin arbiter with bounded hold time per owner.
// Latency: grant registered, visible one cycle after the request is sampled.
// Backpressure: owner keeps the grant while requesting, up to MAX_HOLD cycles when others wait.
//
// Ports:
//   clk          in  : rising-edge clock
//   reset_n      in  : synchronous active-low reset
//   req    [3:0] in  : level-sensitive request lines
//   gnt    [3:0] out : registered one-hot grant, zero when idle
//   gnt_id [1:0] out : binary owner index, zero when idle
//   busy         out : any grant active
module xup_rr_arbiter4
  import xup_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  arb_state_t         state, state_nxt;
  logic [7:0]         hold_cnt, hold_nxt;
  logic [ID_W-1:0]    last, last_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

  // While granting, 'last' equals the owner, so excluding 'last' excludes
  // the owner. In IDLE every requester, including the previous owner, is eligible.
  xup_rr_pick4 u_pick (
    .req   (req),
    .last  (last),
    .excl  (state == ST_GRANT),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last;
    id_nxt    = gnt_id;
    gnt_nxt   = gnt;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt = ST_GRANT;
          id_nxt    = pick_idx;
          last_nxt  = pick_idx;
          gnt_nxt   = onehot_of(pick_idx);
          hold_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (req[gnt_id] && (hold_cnt < HOLD_LIM)) begin
          hold_nxt = hold_cnt + 8'd1;
        end else begin
          // Either the hold budget is spent or the owner let go: hand off
          // to the next waiting requester if there is one.
          hold_nxt = '0;
          if (pick_found) begin
            id_nxt   = pick_idx;
            last_nxt = pick_idx;
            gnt_nxt  = onehot_of(pick_idx);
          end else if (!req[gnt_id]) begin
            state_nxt = ST_IDLE;
            id_nxt    = '0;
            gnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        id_nxt    = '0;
        gnt_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      last     <= ID_W'(NUM_REQ - 1);
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
      busy     <= |gnt_nxt;
    end
  end

endmodule

// File: tb/tb_xup_rr_arbiter4.sv
// Directed bench for the 4-way round-robin arbiter (MAX_HOLD=8 and MAX_HOLD=1).
// Latency: checks grants one cycle after requests are sampled.
// Backpressure: not applicable.
module tb_xup_rr_arbiter4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xup_rr_arbiter4 #(.MAX_HOLD(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a),
    .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a)
  );

  xup_rr_arbiter4 #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b),
    .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later; every cycle both
  // grant vectors must be zero or one-hot.
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot_a", {31'd0, $onehot0(gnt_a)}, 32'd1);
    chk("onehot_b", {31'd0, $onehot0(gnt_b)}, 32'd1);
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, "_gnt"},  {28'd0, gnt_a}, {28'd0, g});
    chk({tag, "_id"},   {30'd0, id_a},  {30'd0, id});
    chk({tag, "_busy"}, {31'd0, busy_a}, {31'd0, (g != 4'd0)});
  endtask

  initial begin
    reset_n = 1'b0;
    req_a   = 4'b0000;
    req_b   = 4'b0000;
    step();
    step();
    chk_a("reset", 4'b0000, 2'd0);
    chk("reset_b_gnt", {28'd0, gnt_b}, 32'd0);

    // Idle with no requests
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a("idle", 4'b0000, 2'd0);
    end

    // All requesting: 0,1,2,3,0 for 8 cycles each
    req_a = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        chk_a($sformatf("rr_o%0d_c%0d", o, c), 4'b0001 << (o % 4), 2'(o % 4));
      end
    end

    // Owner 0 drops, only 2 requests -> 2; then 2 drops with 1001 -> wrap to 3
    req_a = 4'b0100;
    step();
    chk_a("xfer_to2", 4'b0100, 2'd2);
    req_a = 4'b1001;
    step();
    chk_a("wrap_to3", 4'b1000, 2'd3);

    // Lone requester 1 keeps grant past hold limit
    req_a = 4'b0010;
    step();
    chk_a("lone_start", 4'b0010, 2'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_a($sformatf("lone_%0d", i), 4'b0010, 2'd1);
    end

    // Release to idle
    req_a = 4'b0000;
    step();
    chk_a("to_idle", 4'b0000, 2'd0);

    // Reset mid-grant
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req_a   = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a($sformatf("pre_rst_%0d", i), 4'b0010, 2'd1);
    end
    reset_n = 1'b0;
    step();
    chk_a("mid_rst", 4'b0000, 2'd0);
    step();
    chk_a("mid_rst_hold", 4'b0000, 2'd0);
    reset_n = 1'b1;
    step();
    chk_a("post_rst", 4'b0010, 2'd1);

    // MAX_HOLD=1 alternates every cycle
    req_b = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("mh1_gnt_%0d", i), {28'd0, gnt_b}, (i % 2 == 0) ? 32'h1 : 32'h4);
      chk($sformatf("mh1_id_%0d", i),  {30'd0, id_b},  (i % 2 == 0) ? 32'd0 : 32'd2);
      chk($sformatf("mh1_busy_%0d", i), {31'd0, busy_b}, 32'd1);
    end
    req_b = 4'b0000;
    step();
    chk("mh1_idle", {28'd0, gnt_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
